// File: rtl/wallace_final_cpa.sv
// Final carry-propagate adder for the pipelined 32x32 Wallace multiplier.
// Segmented ripple add, one SEG_W slice per stage, with a global valid/ready stall.
module wallace_final_cpa #(
  parameter int unsigned VEC_W  = 65,
  parameter int unsigned PROD_W = 64,
  parameter int unsigned SEG_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [VEC_W-1:0]  sum_in,
  input  logic [VEC_W-1:0]  carry_in,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [PROD_W-1:0] product,
  output logic              out_valid,
  input  logic              out_ready
);

  localparam int unsigned NSEG   = PROD_W / SEG_W;
  localparam int unsigned ADD_W  = SEG_W + 1;
  localparam int unsigned TOP_SH = PROD_W - SEG_W;

  // Stage registers; operands are pre-shifted so each stage consumes bits [SEG_W-1:0]
  logic [NSEG-1:0]   r_vld;
  logic [PROD_W-1:0] r_res [NSEG];
  logic [PROD_W-1:0] r_a   [NSEG-1];
  logic [PROD_W-1:0] r_b   [NSEG-1];
  logic [NSEG-2:0]   r_cy;

  logic              w_adv;
  logic [NSEG-1:0]   w_vld_in;
  logic [NSEG-1:0]   w_cin;
  logic [PROD_W-1:0] w_a_cur   [NSEG];
  logic [PROD_W-1:0] w_b_cur   [NSEG];
  logic [PROD_W-1:0] w_res_cur [NSEG];
  logic [PROD_W-1:0] w_res_nxt [NSEG];
  logic [ADD_W-1:0]  w_add     [NSEG];
  logic              w_unused;

  assign w_adv     = !r_vld[NSEG-1] || out_ready;
  assign in_ready  = w_adv;
  assign out_valid = r_vld[NSEG-1];
  assign product   = r_res[NSEG-1];
  assign w_vld_in  = {r_vld[NSEG-2:0], in_valid};

  // Bit 64 headroom, the final carry-out and the spent operand bits are dropped by design
  assign w_unused = ^{sum_in[VEC_W-1:PROD_W], carry_in[VEC_W-1:PROD_W], w_add[NSEG-1][SEG_W],
                      w_a_cur[NSEG-1][PROD_W-1:SEG_W], w_b_cur[NSEG-1][PROD_W-1:SEG_W]};

  // Per-stage slice add; finished slices enter at the top and shift down each stage
  always_comb begin
    w_a_cur[0]   = sum_in[PROD_W-1:0];
    w_b_cur[0]   = carry_in[PROD_W-1:0];
    w_res_cur[0] = '0;
    w_cin        = '0;
    for (int s = 1; s < NSEG; s++) begin
      w_a_cur[s]   = r_a[s-1];
      w_b_cur[s]   = r_b[s-1];
      w_res_cur[s] = r_res[s-1];
      w_cin[s]     = r_cy[s-1];
    end
    for (int s = 0; s < NSEG; s++) begin
      w_add[s]     = {1'b0, w_a_cur[s][SEG_W-1:0]} + {1'b0, w_b_cur[s][SEG_W-1:0]}
                   + ADD_W'(w_cin[s]);
      w_res_nxt[s] = (w_res_cur[s] >> SEG_W) | (PROD_W'(w_add[s][SEG_W-1:0]) << TOP_SH);
    end
  end

  // Whole pipeline, bubbles included, moves only on global advance
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld <= '0;
      r_cy  <= '0;
      for (int s = 0; s < NSEG; s++) begin
        r_res[s] <= '0;
      end
      for (int s = 0; s < NSEG - 1; s++) begin
        r_a[s] <= '0;
        r_b[s] <= '0;
      end
    end else if (w_adv) begin
      r_vld <= w_vld_in;
      for (int s = 0; s < NSEG; s++) begin
        r_res[s] <= w_res_nxt[s];
      end
      for (int s = 0; s < NSEG - 1; s++) begin
        r_a[s]  <= w_a_cur[s] >> SEG_W;
        r_b[s]  <= w_b_cur[s] >> SEG_W;
        r_cy[s] <= w_add[s][SEG_W];
      end
    end
  end

endmodule

// File: tb/tb_wallace_final_cpa.sv
// Directed and streaming checks for wallace_final_cpa with an in-order product scoreboard.
module tb_wallace_final_cpa;

  localparam int unsigned VEC_W  = 65;
  localparam int unsigned PROD_W = 64;
  localparam int unsigned SEG_W  = 16;
  localparam int unsigned NSEG   = PROD_W / SEG_W;
  localparam int unsigned NDIR   = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic [VEC_W-1:0]  sum_in;
  logic [VEC_W-1:0]  carry_in;
  logic              in_valid;
  logic              in_ready;
  logic [PROD_W-1:0] product;
  logic              out_valid;
  logic              out_ready;

  int                n_vec  = 0;
  int                n_err  = 0;
  int                n_wait = 0;
  bit                sb_en  = 1'b0;
  logic [PROD_W-1:0] exp_q [$];

  // Hand-computed vectors: slice-boundary carries, headroom, discarded carry-out
  logic [VEC_W-1:0]  tv_a [NDIR] = '{
    65'h0_FFFF_FFFE_0000_0000, 65'h1_8000_0000_0000_0000, 65'h0_0000_0000_0000_FFFF,
    65'h0_0000_FFFF_FFFF_0000, 65'h0_1234_5678_9ABC_DEF0, 65'h0_8000_0000_0000_0000,
    65'h0_0000_0000_0000_0000, 65'h1_0000_0000_0000_0005};
  logic [VEC_W-1:0]  tv_b [NDIR] = '{
    65'h0_0000_0000_0000_0001, 65'h1_8000_0000_0000_0000, 65'h0_0000_0000_0000_0001,
    65'h0_0000_0000_0001_0000, 65'h0_0FED_CBA9_8765_4321, 65'h0_8000_0000_0000_0000,
    65'h0_0000_0000_0000_0000, 65'h1_0000_0000_0000_0003};
  logic [PROD_W-1:0] tv_e [NDIR] = '{
    64'hFFFF_FFFE_0000_0001, 64'h0000_0000_0000_0000, 64'h0000_0000_0001_0000,
    64'h0001_0000_0000_0000, 64'h2222_2222_2222_2211, 64'h0000_0000_0000_0000,
    64'h0000_0000_0000_0000, 64'h0000_0000_0000_0008};

  always #5 clk = ~clk;

  wallace_final_cpa dut (
    .clk       (clk),
    .rst       (rst),
    .sum_in    (sum_in),
    .carry_in  (carry_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .product   (product),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  task automatic check(input string tag, input logic [PROD_W-1:0] got,
                       input logic [PROD_W-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Output scoreboard: every output transfer must match the oldest accepted pair
  always @(negedge clk) begin
    if (!rst && sb_en && out_valid && out_ready) begin
      if (exp_q.size() == 0) check("sb_spurious", PROD_W'(exp_q.size()), PROD_W'(1));
      else                   check("sb_product", product, exp_q.pop_front());
    end
  end

  // Present one pair from posedge+1 until accepted; leaves in_valid high
  task automatic send(input logic [VEC_W-1:0] a, input logic [VEC_W-1:0] b,
                      input logic [PROD_W-1:0] e);
    int guard = 0;
    sum_in   = a;
    carry_in = b;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && guard < 50) begin
      @(posedge clk); #1;
      @(negedge clk);
      guard++;
    end
    n_wait += guard;
    if (!in_ready) check("send_timeout", PROD_W'(in_ready), PROD_W'(1));
    else           exp_q.push_back(e);
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int guard = 0;
    in_valid = 1'b0;
    while (exp_q.size() != 0 && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    check("drain_left", PROD_W'(exp_q.size()), PROD_W'(0));
  endtask

  task automatic send_rand();
    logic [VEC_W-1:0]  a;
    logic [VEC_W-1:0]  b;
    logic [PROD_W-1:0] e;
    a = {1'($urandom), $urandom, $urandom};
    b = {1'($urandom), $urandom, $urandom};
    e = a[PROD_W-1:0] + b[PROD_W-1:0];
    send(a, b, e);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, expected finish before 100000ns");
    $fatal(1);
  end

  initial begin
    int w0;
    logic [PROD_W-1:0] hold;
    hold      = '0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    sum_in    = '0;
    carry_in  = '0;
    #12;
    check("rst_out_valid", PROD_W'(out_valid), PROD_W'(0));
    check("rst_product", product, PROD_W'(0));
    @(posedge clk); #1;
    rst   = 1'b0;
    sb_en = 1'b1;
    check("idle_in_ready", PROD_W'(in_ready), PROD_W'(1));

    // Full ripple across every slice, with latency of NSEG-1 edges after acceptance
    send(65'h0_FFFF_FFFF_FFFF_FFFF, 65'h0_0000_0000_0000_0001, 64'h0);
    in_valid = 1'b0;
    for (int k = 0; k < NSEG; k++) begin
      @(negedge clk);
      check($sformatf("latency_edge%0d", k), PROD_W'(out_valid), PROD_W'(k == NSEG - 1));
      @(posedge clk); #1;
    end
    drain();

    for (int i = 0; i < NDIR; i++) send(tv_a[i], tv_b[i], tv_e[i]);
    drain();

    // Back-to-back random stream must never wait on in_ready
    w0 = n_wait;
    for (int i = 0; i < 100; i++) send_rand();
    check("stream_waits", PROD_W'(n_wait - w0), PROD_W'(0));
    drain();

    // Backpressure: hold out_ready low for 5 cycles mid-stream
    fork
      begin
        for (int i = 0; i < 20; i++) send_rand();
        in_valid = 1'b0;
      end
      begin
        repeat (8) @(posedge clk);
        #1 out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
          @(negedge clk);
          check("stall_out_valid", PROD_W'(out_valid), PROD_W'(1));
          check("stall_in_ready", PROD_W'(in_ready), PROD_W'(0));
          if (i == 0) hold = product;
          else        check("stall_product", product, hold);
        end
        @(posedge clk); #1 out_ready = 1'b1;
      end
    join
    drain();

    // Reset with three pairs in flight behind a valid output
    for (int i = 0; i < NSEG; i++) send_rand();
    in_valid = 1'b0;
    check("pre_rst_valid", PROD_W'(out_valid), PROD_W'(1));
    #2 rst = 1'b1;
    #1;
    check("mid_rst_out_valid", PROD_W'(out_valid), PROD_W'(0));
    check("mid_rst_product", product, PROD_W'(0));
    exp_q.delete();
    @(posedge clk); #1 rst = 1'b0;
    for (int i = 0; i < 2 * NSEG; i++) begin
      @(negedge clk);
      check("post_rst_stale", PROD_W'(out_valid), PROD_W'(0));
    end
    @(posedge clk); #1;
    send(65'h0_0000_0000_0000_0002, 65'h0_0000_0000_0000_0003, 64'h5);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
